// File: rtl/maj_sweep_checker.sv
// maj_sweep_checker: exhaustive-sweep self-checker for an N-input majority
// block. Walks x_out through every N-bit vector in ascending order, holds each
// one for SETTLE+1 cycles and compares the DUT's y_dut against a popcount
// threshold reference on the last of those cycles. Reports a saturating
// mismatch count, the first failing vector and a pass flag.
module maj_sweep_checker #(
    parameter int N      = 25,
    parameter int T      = (N + 1) / 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     x_out,
    input  logic             y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N-1:0]     first_err_vec
);

    localparam int PW = $clog2(N + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [SW-1:0]    settle_cnt;
    logic [PW-1:0]    pop;
    logic             ref_y;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    // Reference: population count of the applied vector against the threshold.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(x_out[i]);
        end
    end

    // Zero-extended compare; an unknown y_dut is treated as a mismatch.
    assign ref_y    = (int'(pop) >= T);
    assign mismatch = (y_dut === ref_y) ? 1'b0 : 1'b1;

    // Saturating error-count increment for the vector being checked.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != CNT_MAX)) begin
            err_next = err_count + CNT_W'(1);
        end
    end

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state           <= S_IDLE;
            x_out           <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= S_SETTLE;
                        x_out           <= '0;
                        settle_cnt      <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= x_out;
                    end
                    // The sweep stops at all-ones; x_out is never allowed to wrap.
                    if (x_out == '1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state      <= S_SETTLE;
                        x_out      <= x_out + N'(1);
                        settle_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maj_sweep_checker.sv
// Bench for maj_sweep_checker. Instance A (N=5,T=3,SETTLE=1,CNT_W=16) is
// checked every cycle against a timing/arithmetic model of the sweep; two
// side instances cover SETTLE=3 and a 3-bit saturating counter. Directed
// literal expectations at the end of each sweep pin the model.
module tb_maj_sweep_checker;

    localparam int N  = 5;
    localparam int NV = 1 << N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // y_dut stimulus models: 0 correct majority, 1 stuck at 0, 2 threshold 2.
    function automatic logic y_model(input logic [N-1:0] v, input int mode);
        int pc;
        pc = $countones(v);
        case (mode)
            0:       return pc >= 3;
            1:       return 1'b0;
            default: return pc >= 2;
        endcase
    endfunction

    function automatic bit mism(input int v, input int mode);
        return y_model(N'(v), mode) != ($countones(N'(v)) >= 3);
    endfunction

    // Mismatches whose checking edge ((v+1)*(s+1) edges after start) has passed by edge j.
    function automatic int exp_err(input int j, input int mode, input int s, input int cmax);
        int c;
        c = 0;
        for (int v = 0; v < NV; v++)
            if (mism(v, mode) && (v + 1) * (s + 1) <= j) c++;
        return (c > cmax) ? cmax : c;
    endfunction

    function automatic int exp_first(input int j, input int mode, input int s);
        for (int v = 0; v < NV; v++)
            if (mism(v, mode) && (v + 1) * (s + 1) <= j) return v;
        return -1;
    endfunction

    // ---------------- instance A ----------------
    logic          a_start, a_y, a_busy, a_done, a_pass, a_fev_valid;
    logic [N-1:0]  a_x, a_fev;
    logic [15:0]   a_err;
    int            mode_a;

    assign a_y = y_model(a_x, mode_a);

    maj_sweep_checker #(.N(N), .T(3), .SETTLE(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .x_out(a_x), .y_dut(a_y),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_valid(a_fev_valid), .first_err_vec(a_fev)
    );

    // ---------------- instance B: SETTLE=3, threshold-2 model ----------------
    logic          b_start, b_y, b_busy, b_done, b_pass, b_fev_valid;
    logic [N-1:0]  b_x, b_fev;
    logic [15:0]   b_err;

    assign b_y = y_model(b_x, 2);

    maj_sweep_checker #(.N(N), .T(3), .SETTLE(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .x_out(b_x), .y_dut(b_y),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_valid(b_fev_valid), .first_err_vec(b_fev)
    );

    // ---------------- instance C: CNT_W=3, stuck-at-0 ----------------
    logic          c_start, c_busy, c_done, c_pass, c_fev_valid;
    logic [N-1:0]  c_x, c_fev;
    logic [2:0]    c_err;

    maj_sweep_checker #(.N(N), .T(3), .SETTLE(1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .x_out(c_x), .y_dut(1'b0),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .first_err_valid(c_fev_valid), .first_err_vec(c_fev)
    );

    // ---------------- model of instance A ----------------
    localparam int S_A = 1;
    localparam int L_A = NV * (S_A + 1);
    bit m_zero = 1'b0;
    bit m_run  = 1'b0;
    int m_j    = 0;
    int m_mode = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_zero <= 1'b1;
            m_run  <= 1'b0;
        end else if (a_start && (m_zero || (m_run && m_j >= L_A))) begin
            m_zero <= 1'b0;
            m_run  <= 1'b1;
            m_j    <= 0;
            m_mode <= mode_a;
        end else if (m_run && m_j < 100000) begin
            m_j <= m_j + 1;
        end
    end

    // Per-cycle compare of instance A against the model.
    always @(negedge clk) begin
        int e, f;
        if (m_zero) begin
            check("rst_x", a_x, 0);
            check("rst_busy", a_busy, 0);
            check("rst_done", a_done, 0);
            check("rst_pass", a_pass, 0);
            check("rst_err", a_err, 0);
            check("rst_fev_valid", a_fev_valid, 0);
            check("rst_fev", a_fev, 0);
        end else if (m_run) begin
            e = exp_err(m_j, m_mode, S_A, 65535);
            f = exp_first(m_j, m_mode, S_A);
            if (m_j < L_A) begin
                check("cyc_x", a_x, m_j / (S_A + 1));
                check("cyc_busy", a_busy, 1);
                check("cyc_done", a_done, 0);
            end else begin
                check("cyc_x_end", a_x, NV - 1);
                check("cyc_busy_end", a_busy, 0);
                check("cyc_done_end", a_done, 1);
                check("cyc_pass", a_pass, (e == 0));
            end
            check("cyc_err", a_err, e);
            check("cyc_fev_valid", a_fev_valid, (f >= 0));
            check("cyc_fev", a_fev, (f >= 0) ? f : 0);
        end
    end

    // Pulse start on A (driven between edges), then count cycles until done.
    task automatic sweep_a(input int mode, output int cyc);
        mode_a  = mode;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 0;
        while (cyc < 300 && !a_done) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; mode_a = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1 on A, with B and C launched on the same edge.
        mode_a = 0;
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        cyc = 0;
        while (cyc < 300 && !a_done) begin @(negedge clk); cyc++; end
        check("s1_latency", cyc, 64);
        check("s1_err", a_err, 0);
        check("s1_pass", a_pass, 1);
        check("s1_fev_valid", a_fev_valid, 0);
        check("s1_x", a_x, 5'b11111);
        // C finishes on the same edge as A.
        check("s4_done", c_done, 1);
        check("s4_err_sat", c_err, 7);
        check("s4_fev", c_fev, 5'b00111);
        check("s4_pass", c_pass, 0);
        check("s4_busy", c_busy, 0);
        while (cyc < 300 && !b_done) begin @(negedge clk); cyc++; end
        check("s3_settle3_latency", cyc, 128);
        check("s3_settle3_err", b_err, 10);
        check("s3_settle3_fev", b_fev, 5'b00011);
        check("s3_settle3_pass", b_pass, 0);

        // Scenario 2 with a start pulse injected while busy.
        mode_a  = 1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (10) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 11;
        while (cyc < 300 && !a_done) begin @(negedge clk); cyc++; end
        check("s6_busy_start_latency", cyc, 64);
        check("s2_err", a_err, 16);
        check("s2_fev", a_fev, 5'b00111);
        check("s2_pass", a_pass, 0);

        // Scenario 3 on A: threshold-2 model.
        sweep_a(2, cyc);
        check("s3_latency", cyc, 64);
        check("s3_err", a_err, 10);
        check("s3_fev", a_fev, 5'b00011);

        // Restart from DONE after a failing run with the correct model.
        sweep_a(0, cyc);
        check("s6_rerun_err", a_err, 0);
        check("s6_rerun_pass", a_pass, 1);
        check("s6_rerun_fev_valid", a_fev_valid, 0);

        // Scenario 5: reset mid-sweep, with start asserted alongside (reset wins).
        mode_a  = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1; a_start = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_start = 1'b0;
        check("s5_x", a_x, 0);
        check("s5_busy", a_busy, 0);
        @(negedge clk);
        check("s5_idle_hold_busy", a_busy, 0);
        sweep_a(0, cyc);
        check("s5_restart_latency", cyc, 64);
        check("s5_restart_pass", a_pass, 1);
        check("s5_restart_x", a_x, 5'b11111);
        repeat (3) @(negedge clk);
        check("s5_done_hold", a_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maj_sweep_checker.md
Name: maj_sweep_checker

Overview:
Hardware exhaustive-sweep self-checker for the N-input majority top.
- Upstream role: drives every N-bit vector, 0 .. 2^N-1 ascending, onto the DUT inputs.
- Downstream role: samples the DUT's y0 and compares it against an internal popcount-threshold reference.
- Reports mismatch count, first failing vector and a pass flag.
- Lets the majority netlist be validated on FPGA/emulation without a simulator-side loop.

Parameters:
N, 25, number of majority inputs; x_out width.
T, 13, reference threshold; ref = (popcount(x_out) >= T). Default is (N+1)/2.
SETTLE, 1, cycles x_out is held before y_dut is sampled. Must be >= 1.
CNT_W, 16, width of the saturating mismatch counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begins a sweep when in IDLE or DONE.
x_out  output  N  vector applied to DUT x0..x(N-1); bit i drives xi.
y_dut  input  1  DUT y0 output.
busy  output  1  high in SETTLE and CHECK.
done  output  1  high in DONE.
pass  output  1  valid while done=1; 1 iff err_count==0.
err_count  output  CNT_W  number of mismatching vectors, saturating at 2^CNT_W-1.
first_err_valid  output  1  high once any mismatch has been recorded.
first_err_vec  output  N  x_out value of the first mismatch.

Behaviour:
Reset (rst=1 at a clock edge, from any state):
- State becomes IDLE.
- x_out, err_count, first_err_vec, first_err_valid, busy, done, pass all become 0.
- Internal settle counter cleared.
- Reset mid-sweep abandons the sweep; nothing is retained.

FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1:
  - x_out<=0, settle_cnt<=0.
  - err_count, first_err_valid and first_err_vec cleared.
  - Next state SETTLE.
- SETTLE:
  - If settle_cnt==SETTLE-1, go to CHECK; otherwise settle_cnt++.
  - x_out is stable throughout.
- CHECK:
  - At the clock edge, compare y_dut with ref(x_out).
  - On mismatch: err_count++ unless saturated. If first_err_valid==0, also set first_err_vec<=x_out and first_err_valid<=1.
  - If x_out == all-ones, go to DONE with x_out held.
  - Otherwise x_out<=x_out+1, settle_cnt<=0, go to SETTLE.
- DONE:
  - done=1; pass=(err_count==0).
  - start=1 behaves exactly as from IDLE (full clear, restart at vector 0).

Timing and rules:
- Each vector is held for exactly SETTLE+1 cycles; the sample is taken on the last of those cycles.
- From the cycle start is sampled to done=1: 2^N*(SETTLE+1) cycles.
- start while busy: ignored.
- start together with rst: reset wins.
- The reference is computed combinationally from the registered x_out.
  - Popcount width is clog2(N+1) bits, zero-extended comparison.
  - No X propagation permitted: y_dut is treated as-is, and an X on y_dut counts as a mismatch in simulation.
- x_out never wraps: the sweep ends at all-ones. The internal increment must not be allowed to roll over to 0 and continue.
- busy and done are never high simultaneously.

Test Plan:
(Benches use N=5, T=3, SETTLE=1 unless noted.)
1. Correct majority model on y_dut, pulse start → done=1 exactly 64 cycles later. err_count=0, pass=1, first_err_valid=0, x_out=5'b11111.
2. y_dut stuck at 0 → err_count=16 (vectors with popcount>=3), first_err_vec=5'b00111, pass=0.
3. Model with threshold 2 → err_count=10 (popcount==2 vectors), first_err_vec=5'b00011. With SETTLE=3 the result is identical and done arrives after 128 cycles.
4. CNT_W=3 with y_dut stuck at 0 → err_count saturates at 7, first_err_vec=5'b00111, pass=0.
5. Assert rst at cycle 20 of a sweep → the next cycle shows IDLE, all outputs 0. A subsequent start completes normally with scenario-1 results.
6. Pulse start while busy → no effect on x_out sequence or timing. A start pulse in DONE after a failing run clears err_count and first_err_valid; rerun with the correct model gives pass=1.
